// File: rtl/npu_ctrl_pkg.sv
// Shared definitions for the NPU filter MAC job controller.
package npu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ACC   = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Stored results are clamped to the 8-bit LED range.
  localparam int SAT_MAX = 255;
  localparam int SAT_MIN = 0;

  localparam int N_TAPS_DEF    = 8;
  localparam int N_OUT_DEF     = 4;
  localparam int MAX_RETRY_DEF = 2;

endpackage

// File: rtl/npu_edge_det.sv
// One-bit rising-edge detector; the history register updates every cycle.
module npu_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // History register, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/npu_mac_sched.sv
// Job controller for the shared MAC datapath of the NPU filter.
// Computes N_OUT outputs of N_TAPS taps each, retries outputs whose
// computation saw a MAC/multiplier error, and buffers saturated results
// for stepping onto the LED bus.
//
// state | meaning
// IDLE  | waiting for a start edge; next edges step the read pointer
// CLR   | clear accumulator, reset tap counter and error flag
// ACC   | one tap per cycle, N_TAPS cycles
// WAIT  | datapath registers the final product
// STORE | retry on error, else write saturated result
// DONE  | one-cycle completion pulse
module npu_mac_sched
  import npu_ctrl_pkg::*;
#(
  parameter int N_TAPS    = N_TAPS_DEF,
  parameter int N_OUT     = N_OUT_DEF,
  parameter int ACC_W     = 16,
  parameter int SA_W      = 4,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    c_select,
  input  logic                          next,
  input  logic                          err_mac,
  input  logic                          err_mult,
  input  logic signed [ACC_W-1:0]       acc_in,
  output logic                          mac_clr,
  output logic                          mac_en,
  output logic [2+$clog2(N_TAPS)-1:0]   coef_addr,
  output logic [SA_W-1:0]               samp_addr,
  output logic [7:0]                    led,
  output logic                          busy,
  output logic                          done,
  output logic                          fault
);

  localparam int TW = $clog2(N_TAPS);
  localparam int OW = $clog2(N_OUT);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_CLR   = S_CLR;
  localparam logic [2:0] ST_ACC   = S_ACC;
  localparam logic [2:0] ST_WAIT  = S_WAIT;
  localparam logic [2:0] ST_STORE = S_STORE;
  localparam logic [2:0] ST_DONE  = S_DONE;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);

  logic [2:0]    state_q;
  logic [1:0]    sel_q;
  logic [OW-1:0] out_idx;
  logic [TW-1:0] tap;
  logic [RW-1:0] retry;
  logic          err_flag;
  logic [OW-1:0] rd_ptr;
  logic [7:0]    res_buf [N_OUT];

  logic start_rise;
  logic next_rise;
  logic err_any;
  logic [7:0] acc_sat;

  npu_edge_det u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (start),
    .rise (start_rise)
  );

  npu_edge_det u_next_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (next),
    .rise (next_rise)
  );

  assign err_any = err_mac | err_mult;

  // Clamp the signed accumulator into the unsigned 8-bit result range.
  always_comb begin
    acc_sat = acc_in[7:0];
    if (acc_in < SAT_LO)      acc_sat = 8'(SAT_MIN);
    else if (acc_in > SAT_HI) acc_sat = 8'(SAT_MAX);
  end

  // Strobes and addresses are decoded from state; addresses idle at zero.
  always_comb begin
    mac_clr   = (state_q == ST_CLR);
    mac_en    = (state_q == ST_ACC);
    coef_addr = '0;
    samp_addr = '0;
    if (state_q == ST_ACC) begin
      coef_addr = {sel_q, tap};
      samp_addr = SA_W'(out_idx) + SA_W'(tap);
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign led  = res_buf[rd_ptr];

  // Job sequencing, retry bookkeeping and result buffer writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      out_idx  <= '0;
      tap      <= '0;
      retry    <= '0;
      err_flag <= 1'b0;
      rd_ptr   <= '0;
      fault    <= 1'b0;
      for (int i = 0; i < N_OUT; i++) res_buf[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            sel_q   <= c_select;
            out_idx <= '0;
            retry   <= '0;
            rd_ptr  <= '0;
            fault   <= 1'b0;
            state_q <= ST_CLR;
          end else if (next_rise) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end

        ST_CLR: begin
          tap      <= '0;
          err_flag <= 1'b0;
          state_q  <= ST_ACC;
        end

        ST_ACC: begin
          err_flag <= err_flag | err_any;
          tap      <= tap + 1'b1;
          if (tap == TW'(N_TAPS - 1)) state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          err_flag <= err_flag | err_any;
          state_q  <= ST_STORE;
        end

        ST_STORE: begin
          if (err_flag && (retry < RW'(MAX_RETRY))) begin
            retry   <= retry + 1'b1;
            state_q <= ST_CLR;
          end else begin
            res_buf[out_idx] <= acc_sat;
            retry            <= '0;
            if (err_flag) fault <= 1'b1;
            if (out_idx == OW'(N_OUT - 1)) begin
              state_q <= ST_DONE;
            end else begin
              out_idx <= out_idx + 1'b1;
              state_q <= ST_CLR;
            end
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_mac_sched.sv
// Self-checking bench for npu_mac_sched with a behavioural MAC datapath.
module tb_npu_mac_sched;

  localparam int N_TAPS    = 8;
  localparam int N_OUT     = 4;
  localparam int ACC_W     = 16;
  localparam int SA_W      = 4;
  localparam int MAX_RETRY = 2;
  localparam int CW        = 2 + $clog2(N_TAPS);

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] c_select;
  logic next;
  logic err_mac;
  logic err_mult;
  logic signed [ACC_W-1:0] acc_in;
  logic mac_clr;
  logic mac_en;
  logic [CW-1:0] coef_addr;
  logic [SA_W-1:0] samp_addr;
  logic [7:0] led;
  logic busy;
  logic done;
  logic fault;

  always #5 clk = ~clk;

  npu_mac_sched #(
    .N_TAPS(N_TAPS), .N_OUT(N_OUT), .ACC_W(ACC_W), .SA_W(SA_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .c_select(c_select), .next(next),
    .err_mac(err_mac), .err_mult(err_mult), .acc_in(acc_in),
    .mac_clr(mac_clr), .mac_en(mac_en), .coef_addr(coef_addr), .samp_addr(samp_addr),
    .led(led), .busy(busy), .done(done), .fault(fault)
  );

  int vectors = 0;
  int miscompares = 0;

  int coef_mem [4][N_TAPS];
  int samp_mem [16];
  int acc = 0;
  int overlap_cnt = 0;

  bit err_mac_at  [1024];
  bit err_mult_at [1024];
  int mid_cyc;
  bit hold_start;
  int done_cyc;

  int exp_buf [N_OUT];
  int got_buf [N_OUT];
  int exp_done;
  bit exp_fault;

  // Behavioural datapath: registered accumulator of coef*sample.
  always @(posedge clk) begin
    if (!rst) acc <= 0;
    else if (mac_clr) acc <= 0;
    else if (mac_en) acc <= acc + coef_mem[coef_addr[CW-1:CW-2]][coef_addr[CW-3:0]] * samp_mem[samp_addr];
  end
  assign acc_in = acc[ACC_W-1:0];

  always @(negedge clk) if (mac_en && mac_clr) overlap_cnt++;

  task automatic clear_errs();
    for (int i = 0; i < 1024; i++) begin
      err_mac_at[i]  = 1'b0;
      err_mult_at[i] = 1'b0;
    end
    mid_cyc    = -1;
    hold_start = 1'b0;
  endtask

  task automatic init_basic();
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < N_TAPS; t++) coef_mem[s][t] = (s == 0) ? 1 : 0;
    for (int i = 0; i < 16; i++) samp_mem[i] = i;
  endtask

  // Reference: each attempt is 11 cycles starting with CLR; errors count in
  // the ACC and WAIT cycles of the attempt.
  task automatic model(input logic [1:0] sel);
    int t;
    int r;
    int s;
    bit e;
    t = 1;
    exp_fault = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      r = 0;
      while (1) begin
        e = 1'b0;
        for (int c = t + 1; c <= t + N_TAPS + 1; c++)
          if (err_mac_at[c] || err_mult_at[c]) e = 1'b1;
        t += N_TAPS + 3;
        if (e && r < MAX_RETRY) r++;
        else begin
          if (e) exp_fault = 1'b1;
          break;
        end
      end
      s = 0;
      for (int tt = 0; tt < N_TAPS; tt++) s += coef_mem[sel][tt] * samp_mem[k + tt];
      exp_buf[k] = (s < 0) ? 0 : (s > 255) ? 255 : s;
    end
    exp_done = t;
  endtask

  task automatic run_job(input logic [1:0] sel);
    int cyc;
    @(negedge clk);
    c_select = sel;
    start    = 1'b1;
    err_mac  = err_mac_at[0];
    err_mult = err_mult_at[0];
    cyc      = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 600) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) done_cyc = cyc;
      err_mac  = err_mac_at[cyc];
      err_mult = err_mult_at[cyc];
      if (!hold_start && cyc == 3) start = 1'b0;
      if (cyc == mid_cyc) begin
        c_select = ~sel;
        start    = 1'b1;
      end
      if (mid_cyc >= 0 && cyc == mid_cyc + 2) start = 1'b0;
    end
    err_mac  = 1'b0;
    err_mult = 1'b0;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reads all buffered results through the LED bus; leaves rd_ptr at 0.
  task automatic read_bufs();
    for (int k = 0; k < N_OUT; k++) begin
      @(negedge clk);
      got_buf[k] = led;
      pulse_next();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; next = 1'b0; c_select = 2'd0;
    err_mac = 1'b0; err_mult = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, mac_en, mac_clr, fault} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy/done/en/clr/fault=%b want 00000", {busy, done, mac_en, mac_clr, fault});
    end
    vectors++;
    if (led !== 8'd0 || coef_addr !== '0 || samp_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got led=%0d coef=%0d samp=%0d want 0", led, coef_addr, samp_addr);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    init_basic();
    clear_errs();
    hold_start = 1'b1;
    model(2'd0);
    run_job(2'd0);
    vectors++;
    if (done_cyc !== exp_done) begin
      miscompares++;
      $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, exp_done);
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_no_retrigger: got busy=%b want 0", busy);
      end
    end
    start = 1'b0;
    vectors++;
    if (fault !== exp_fault) begin
      miscompares++;
      $display("FAIL basic_fault: got %b want %b", fault, exp_fault);
    end
    read_bufs();
    for (int k = 0; k < N_OUT; k++) begin
      vectors++;
      if (got_buf[k] !== exp_buf[k]) begin
        miscompares++;
        $display("FAIL basic_buf%0d: got %0d want %0d", k, got_buf[k], exp_buf[k]);
      end
    end
  endtask

  task automatic test_stepping();
    int exp_seq [4];
    exp_seq[0] = exp_buf[1]; exp_seq[1] = exp_buf[2]; exp_seq[2] = exp_buf[3]; exp_seq[3] = exp_buf[0];
    for (int i = 0; i < 4; i++) begin
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (9) @(negedge clk);
      vectors++;
      if (led !== 8'(exp_seq[i])) begin
        miscompares++;
        $display("FAIL step%0d: got led=%0d want %0d", i, led, exp_seq[i]);
      end
    end
    next = 1'b1;
    repeat (5) @(negedge clk);
    next = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (led !== 8'(exp_buf[1])) begin
      miscompares++;
      $display("FAIL step_held: got led=%0d want %0d", led, exp_buf[1]);
    end
    repeat (3) pulse_next();
  endtask

  task automatic test_single_retry();
    init_basic();
    clear_errs();
    err_mult_at[15] = 1'b1;
    model(2'd0);
    run_job(2'd0);
    vectors++;
    if (done_cyc !== exp_done) begin
      miscompares++;
      $display("FAIL retry_done_cycle: got %0d want %0d", done_cyc, exp_done);
    end
    vectors++;
    if (fault !== exp_fault) begin
      miscompares++;
      $display("FAIL retry_fault: got %b want %b", fault, exp_fault);
    end
    read_bufs();
    for (int k = 0; k < N_OUT; k++) begin
      vectors++;
      if (got_buf[k] !== exp_buf[k]) begin
        miscompares++;
        $display("FAIL retry_buf%0d: got %0d want %0d", k, got_buf[k], exp_buf[k]);
      end
    end
  endtask

  task automatic test_exhausted();
    init_basic();
    clear_errs();
    for (int c = 0; c < 200; c++) err_mac_at[c] = 1'b1;
    model(2'd0);
    run_job(2'd0);
    vectors++;
    if (done_cyc !== exp_done) begin
      miscompares++;
      $display("FAIL exhaust_done_cycle: got %0d want %0d", done_cyc, exp_done);
    end
    vectors++;
    if (fault !== exp_fault) begin
      miscompares++;
      $display("FAIL exhaust_fault: got %b want %b", fault, exp_fault);
    end
    read_bufs();
    for (int k = 0; k < N_OUT; k++) begin
      vectors++;
      if (got_buf[k] !== exp_buf[k]) begin
        miscompares++;
        $display("FAIL exhaust_buf%0d: got %0d want %0d", k, got_buf[k], exp_buf[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    init_basic();
    clear_errs();
    @(negedge clk);
    c_select = 2'd0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      @(negedge clk);
      if (cyc == 3) start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    vectors++;
    if ({busy, mac_en, fault} !== 3'b0 || led !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: got busy/en/fault=%b led=%0d want 000 led=0", {busy, mac_en, fault}, led);
    end
    read_bufs();
    for (int k = 0; k < N_OUT; k++) begin
      vectors++;
      if (got_buf[k] !== 0) begin
        miscompares++;
        $display("FAIL midreset_buf%0d: got %0d want 0", k, got_buf[k]);
      end
    end
    model(2'd0);
    run_job(2'd0);
    vectors++;
    if (done_cyc !== exp_done) begin
      miscompares++;
      $display("FAIL midreset_rerun_done: got %0d want %0d", done_cyc, exp_done);
    end
    read_bufs();
    vectors++;
    if (got_buf[3] !== exp_buf[3]) begin
      miscompares++;
      $display("FAIL midreset_rerun_buf3: got %0d want %0d", got_buf[3], exp_buf[3]);
    end
  endtask

  task automatic test_saturation();
    init_basic();
    clear_errs();
    for (int t = 0; t < N_TAPS; t++) begin
      coef_mem[3][t] = 100;
      coef_mem[2][t] = -1;
    end
    for (int i = 0; i < 16; i++) samp_mem[i] = 1;
    for (int s = 3; s >= 2; s--) begin
      mid_cyc = (s == 3) ? 20 : -1;
      model(2'(s));
      run_job(2'(s));
      vectors++;
      if (done_cyc !== exp_done) begin
        miscompares++;
        $display("FAIL sat_set%0d_done: got %0d want %0d", s, done_cyc, exp_done);
      end
      repeat (3) @(negedge clk);
      read_bufs();
      for (int k = 0; k < N_OUT; k++) begin
        vectors++;
        if (got_buf[k] !== exp_buf[k]) begin
          miscompares++;
          $display("FAIL sat_set%0d_buf%0d: got %0d want %0d", s, k, got_buf[k], exp_buf[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] sel;
    int n_err;
    int c;
    for (int it = 0; it < 4; it++) begin
      clear_errs();
      sel = 2'($urandom_range(3));
      for (int t = 0; t < N_TAPS; t++) coef_mem[sel][t] = int'($urandom_range(60)) - 20;
      for (int i = 0; i < 16; i++) samp_mem[i] = int'($urandom_range(30));
      n_err = int'($urandom_range(2));
      for (int e = 0; e < n_err; e++) begin
        c = int'($urandom_range(140, 1));
        if ($urandom_range(1) == 0) err_mac_at[c] = 1'b1;
        else err_mult_at[c] = 1'b1;
      end
      model(sel);
      run_job(sel);
      vectors++;
      if (done_cyc !== exp_done) begin
        miscompares++;
        $display("FAIL rand%0d_done: got %0d want %0d", it, done_cyc, exp_done);
      end
      vectors++;
      if (fault !== exp_fault) begin
        miscompares++;
        $display("FAIL rand%0d_fault: got %b want %b", it, fault, exp_fault);
      end
      read_bufs();
      for (int k = 0; k < N_OUT; k++) begin
        vectors++;
        if (got_buf[k] !== exp_buf[k]) begin
          miscompares++;
          $display("FAIL rand%0d_buf%0d: got %0d want %0d", it, k, got_buf[k], exp_buf[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stepping();
    test_single_retry();
    test_exhausted();
    test_reset_mid();
    test_saturation();
    test_random();
    vectors++;
    if (overlap_cnt !== 0) begin
      miscompares++;
      $display("FAIL strobe_overlap: got %0d cycles with mac_en&mac_clr want 0", overlap_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/npu_mac_sched.md
Name: npu_mac_sched

Overview:
- Job controller that sequences the shared MAC datapath of the NPU filter.
- On a start pulse it latches the coefficient-set select, then computes N_OUT outputs of N_TAPS taps each. For every tap it drives coefficient and sample addresses and the MAC enable/clear strobes.
- It watches the injected MAC/multiplier error flags and retries a corrupted output, up to MAX_RETRY times.
- It stores saturated results in an internal buffer, which the user steps through onto the LED bus with the next button.

Parameters:
- N_TAPS, 8, taps per output; power of 2, ≥2.
- N_OUT, 4, outputs per job; power of 2, ≥2.
- ACC_W, 16, signed accumulator width from the datapath.
- SA_W, 4, sample-address width; must hold N_OUT+N_TAPS-2.
- MAX_RETRY, 2, recomputations allowed per output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  job request, level; rising edge triggers.
- c_select  in  2  coefficient set; sampled only at job start.
- next  in  1  result-step button, level; rising edge steps.
- err_mac  in  1  MAC fault indication.
- err_mult  in  1  multiplier fault indication.
- acc_in  in  ACC_W  signed accumulator value from the datapath.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate this cycle.
- coef_addr  out  2+log2(N_TAPS)  address = {sel_q, tap}.
- samp_addr  out  SA_W  address = out_idx + tap.
- led  out  8  buf[rd_ptr].
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- fault  out  1  sticky: some output exhausted its retries.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs 0; buf[*]=0; rd_ptr, out_idx, tap, retry, err_flag all 0.
  - Edge-detector history regs = 0.
  - Reset wins over every other event, including mid-job.
- Edge detection:
  - start_rise = start & ~start_q.
  - next_rise = next & ~next_q.
  - The history regs update every cycle.
- State sequence: IDLE, CLR, ACC, WAIT, STORE, DONE.
- IDLE:
  - On start_rise: sel_q<=c_select, out_idx<=0, retry<=0, rd_ptr<=0, fault<=0; go to CLR.
  - next_rise is honoured only in IDLE: rd_ptr<=(rd_ptr+1) mod N_OUT.
- CLR:
  - mac_clr=1 for one cycle; tap<=0, err_flag<=0.
  - Go to ACC.
- ACC (N_TAPS cycles):
  - mac_en=1; coef_addr={sel_q,tap}; samp_addr=out_idx+tap.
  - err_flag|=err_mac|err_mult; tap++.
  - When tap==N_TAPS-1, go to WAIT.
- WAIT (1 cycle):
  - Lets the datapath register the final product.
  - err_flag still ORs the error inputs; go to STORE.
- STORE, evaluated in priority order:
  - err_flag && retry<MAX_RETRY: retry++, go to CLR (same out_idx, nothing written).
  - Otherwise: buf[out_idx]<=sat(acc_in); retry<=0; if err_flag, set fault. Then:
    - out_idx==N_OUT-1: go to DONE.
    - else: out_idx++, go to CLR.
- DONE: done=1 for one cycle; go to IDLE.
- busy=1 in every state except IDLE.
- Saturation sat(): acc_in<0 → 0; acc_in>255 → 255; otherwise acc_in[7:0].
- Ignored while busy: start, next and c_select changes. A start held high across DONE does not retrigger, because an edge is needed.
- Timing (error-free):
  - Each output costs N_TAPS+3 cycles.
  - start_rise is seen in IDLE at cycle 0; done pulses at cycle 1+N_OUT*(N_TAPS+3), i.e. 45 with the defaults.
  - Each retry adds N_TAPS+3 cycles.
- led is combinational from buf and rd_ptr.
- mac_en and mac_clr are never high together.

Decomposition:
- Package npu_ctrl_pkg holds:
  - the state enum;
  - saturation constants SAT_MAX=255 and SAT_MIN=0;
  - the default N_TAPS, N_OUT and MAX_RETRY.
- One sub-module, npu_edge_det (1-bit rising-edge detector with synchronous active-low reset), instantiated twice: for start and for next.

Test Plan:
- Bench datapath model: coef=1 for all taps of set 0, sample[i]=i, c_select=0; pulse start → done at cycle 45; buf = 28,36,44,52; led=28; fault=0.
- Stepping: after the job, give three next rising edges 10 cycles apart → led = 36, 44, 52; a fourth edge → led wraps to 28. next held high for 5 cycles → exactly one step.
- Single retry: assert err_mult for 1 cycle during ACC of output 1 → output 1 recomputed once; done at cycle 56; buf correct; fault=0.
- Exhausted retries: err_mac held high for a whole job → each output computed 3 times; done at cycle 1+4*3*11=133; fault=1; buf still written with the saturated values.
- Saturation and select: set 3 coefs=100 with sample=1 → buf=255; set 2 coefs=-1 → buf=0. Change c_select and pulse start mid-job → no effect on the running job.
- Reset mid-job: rst=0 during ACC of output 2 → next cycle: busy=0, mac_en=0, led=0, buf cleared; a new start then runs normally to done at cycle 45.
